// File: rtl/axi_stream_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_stream_fifo : first-word-fall-through AXI4-Stream FIFO with level and
// packet counters.  Rev 1.0
// ---------------------------------------------------------------------------
module axi_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_W-1:0]      level,
  output logic [CNT_W-1:0]      pkt_count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;

  logic             push;
  logic             pop;
  logic             push_last;
  logic             pop_last;
  logic [CNT_W-1:0] level_nxt;
  logic [CNT_W-1:0] pkt_count_nxt;

  assign push      = s_tvalid && s_tready;
  assign pop       = m_tvalid && m_tready;
  assign push_last = push && s_tlast;
  assign pop_last  = pop && m_tlast;

  always_comb begin
    level_nxt     = level + CNT_W'(push) - CNT_W'(pop);
    pkt_count_nxt = pkt_count + CNT_W'(push_last) - CNT_W'(pop_last);
  end

  // Head entry is read combinationally so data is valid alongside the registered m_tvalid.
  assign {m_tlast, m_tdata} = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      m_tvalid  <= 1'b0;
      s_tready  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      level     <= level_nxt;
      pkt_count <= pkt_count_nxt;
      // Both handshake flags come from the next-state level, so neither
      // depends combinationally on the opposite side's inputs.
      m_tvalid  <= (level_nxt != '0);
      s_tready  <= (level_nxt < CNT_W'(DEPTH));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_fifo.sv
`default_nettype none
// Randomised and directed bench for axi_stream_fifo with a queue-based
// reference model checked by an independent monitor.
module tb_axi_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [CW-1:0] level;
  logic [CW-1:0] pkt_count;

  int compared = 0;
  int mismatched = 0;

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .level     (level),
    .pkt_count (pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of accepted {tlast, tdata} beats.
  logic [DW:0] model_q[$];
  bit          started = 0;
  bit          rst_pending = 0;

  function automatic int model_pkts();
    int n = 0;
    foreach (model_q[i]) if (model_q[i][DW]) n++;
    return n;
  endfunction

  // Monitor: sampled 1 time unit after each falling edge, when every signal
  // feeding the next rising edge is stable.
  always @(negedge aclk) begin
    #1;
    if (rst_pending) begin
      model_q.delete();
      started = 1;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
    end else if (started) begin
      chk("level", 64'(level), 64'(model_q.size()));
      chk("pkt_count", 64'(pkt_count), 64'(model_pkts()));
      chk("m_tvalid", 64'(m_tvalid), 64'(model_q.size() != 0));
      chk("s_tready", 64'(s_tready), 64'(model_q.size() < DEPTH));
      if (m_tvalid && model_q.size() != 0)
        chk("head_beat", 64'({m_tlast, m_tdata}), 64'(model_q[0]));
    end
    rst_pending = areset;
    if (!areset && started) begin
      if (m_tvalid && m_tready && model_q.size() != 0) void'(model_q.pop_front());
      if (s_tvalid && s_tready) model_q.push_back({s_tlast, s_tdata});
    end
  end

  // Offer one beat, holding it until accepted or max_wait cycles pass.
  task automatic push_beat(input logic [DW-1:0] d, input logic l, input int max_wait,
                           output bit ok);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      ok = s_tready;
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 64 && level != 0; i++) @(negedge aclk);
    m_tready = 1'b0;
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_pkt_count", 64'(pkt_count), 64'd0);
  endtask

  initial begin
    bit ok;
    int acc;
    int cyc;
    logic [31:0] base;

    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_release", 64'(s_tready), 64'd1);

    // 1: eight beats streamed straight through
    m_tready = 1'b1;
    base = 32'hdeadbeef;
    for (int i = 0; i < 8; i++) begin
      push_beat(base + 32'(i), (i == 7), 8, ok);
      chk("t1_accept", 64'(ok), 64'd1);
    end
    drain();

    // 2: backpressure, fill to full
    m_tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push_beat(32'h1000 + 32'(i), 1'b0, 3, ok);
      if (ok) acc++;
    end
    chk("t2_accepted", 64'(acc), 64'd8);
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_s_tready", 64'(s_tready), 64'd0);
    m_tready = 1'b1;
    @(negedge aclk);
    m_tready = 1'b0;
    @(negedge aclk);
    chk("t2_ready_after_pop", 64'(s_tready), 64'd1);
    drain();

    // 3: steady-state streaming at level 4
    for (int i = 0; i < 4; i++) push_beat(32'h2000 + 32'(i), 1'b0, 8, ok);
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_beat(32'h3000 + 32'(i), (i % 5 == 4), 8, ok);
      chk("t3_accept", 64'(ok), 64'd1);
    end
    m_tready = 1'b0;
    chk("t3_level", 64'(level), 64'd4);
    drain();

    // 4: packet counting
    push_beat(32'h40, 1'b1, 8, ok);
    push_beat(32'h41, 1'b0, 8, ok);
    push_beat(32'h42, 1'b1, 8, ok);
    push_beat(32'h43, 1'b0, 8, ok);
    push_beat(32'h44, 1'b0, 8, ok);
    push_beat(32'h45, 1'b1, 8, ok);
    chk("t4_level", 64'(level), 64'd6);
    chk("t4_pkt_count", 64'(pkt_count), 64'd3);
    m_tready = 1'b1;
    repeat (3) @(negedge aclk);
    m_tready = 1'b0;
    chk("t4_pkt_after_pop", 64'(pkt_count), 64'd1);
    drain();

    // 5: reset mid-operation with a beat offered during reset
    for (int i = 0; i < 5; i++) push_beat(32'h5000 + 32'(i), 1'b0, 8, ok);
    chk("t5_level", 64'(level), 64'd5);
    areset   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'hbad0bad0;
    s_tlast  = 1'b1;
    @(negedge aclk);
    areset   = 1'b0;
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("t5_ready_after_release", 64'(s_tready), 64'd1);
    chk("t5_no_stale_valid", 64'(m_tvalid), 64'd0);

    // 6: random traffic; the offered beat is held until accepted
    acc = 0;
    cyc = 0;
    ok  = 0;
    while (acc < 1000 && cyc < 20000) begin
      if (!s_tvalid || ok) begin
        s_tvalid = ($urandom_range(0, 1) == 1);
        s_tdata  = $urandom;
        s_tlast  = ($urandom_range(0, 3) == 0);
      end
      m_tready = ($urandom_range(0, 1) == 1);
      ok = s_tvalid && s_tready;
      if (ok) acc++;
      @(negedge aclk);
      cyc++;
    end
    s_tvalid = 1'b0;
    chk("t6_beats_accepted", 64'(acc), 64'd1000);
    drain();

    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_stream_fifo.md
Name: axi_stream_fifo

Overview:
Synchronous AXI4-Stream FIFO placed directly downstream of axi_stream_master, between it and axi_stream_slave. It absorbs backpressure, decouples the two handshakes and carries tdata/tlast through in order. It also reports occupancy and the number of complete packets buffered, for debug and flow control.

Parameters:
DATA_WIDTH, 32, tdata width (matches data_t in axi_stream_pkg).
DEPTH, 8, number of entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, width of level and packet counters (localparam).

Ports:
aclk  input  1  clock; all logic on rising edge.
areset  input  1  synchronous, active-high reset.
s_tdata  input  DATA_WIDTH  upstream data.
s_tvalid  input  1  upstream valid.
s_tready  output  1  FIFO can accept a beat.
s_tlast  input  1  upstream end of packet.
m_tdata  output  DATA_WIDTH  head-of-FIFO data.
m_tvalid  output  1  FIFO non-empty.
m_tready  input  1  downstream ready.
m_tlast  output  1  tlast of head entry.
level  output  CNT_W  entries currently stored, 0..DEPTH.
pkt_count  output  CNT_W  stored entries with tlast=1.

Behaviour:
- Clock is aclk; reset is synchronous and active-high (areset); one clock domain.
- Reset (sampled at aclk edge): wr_ptr=0, rd_ptr=0, level=0, pkt_count=0, m_tvalid=0, s_tready=0. Memory contents are not reset. m_tdata/m_tlast are don't-care while m_tvalid=0.
- s_tready is registered. It is 0 during reset and rises on the first edge after areset deasserts. Thereafter, s_tready is 1 iff the next-state level < DEPTH.
- Push occurs when s_tvalid && s_tready. The FIFO writes {s_tlast, s_tdata} at wr_ptr and increments wr_ptr, which wraps modulo DEPTH.
- Pop occurs when m_tvalid && m_tready. rd_ptr increments and wraps modulo DEPTH.
- First-word fall-through:
  - m_tvalid = (level != 0), registered.
  - m_tdata/m_tlast present the entry at rd_ptr.
  - A beat pushed into an empty FIFO appears on m_* the following cycle (latency 1). There is no same-cycle bypass.
- Simultaneous push and pop: level is unchanged, and both pointers advance.
  - Full: push is impossible (s_tready=0). A pop while full raises s_tready on the next cycle.
  - Empty: pop is impossible (m_tvalid=0).
- level update: +1 on push only, -1 on pop only, otherwise held. level never exceeds DEPTH and never goes below 0.
- pkt_count update: +1 when a pushed beat has tlast=1; -1 when a popped beat has tlast=1; both in the same cycle nets to no change.
- AXI rules:
  - m_tvalid, once high, stays high and m_tdata/m_tlast stay stable until a pop.
  - No combinational path from m_tready to s_tready, or from s_tvalid to m_tvalid.
- Reset mid-operation: all buffered beats are discarded. Outputs take their reset values at the edge where areset=1 is sampled. Any beats presented during reset are not accepted.

Test Plan:
1. After reset release, push 8 beats 0xdeadbeef..0xdeadbef6 (tlast on the 8th) with m_tready=1 -> m_* delivers the same 8 values in order, each 1 cycle after acceptance; m_tlast=1 only on 0xdeadbef6; final level=0, pkt_count=0.
2. Hold m_tready=0 and offer 10 beats -> exactly 8 are accepted; s_tready drops the cycle after the 8th push; level=8. Then raise m_tready -> the 8 values drain in order and s_tready returns 1 the cycle after the first pop.
3. Fill to level=4, then hold s_tvalid=1 and m_tready=1 for 20 cycles with an incrementing pattern -> level stays 4, output sequence is gap-free and in order, and both pointers wrap at least twice.
4. Push 3 packets of lengths 1, 2 and 3 with m_tready=0 -> level=6, pkt_count=3. Pop 3 beats -> pkt_count=1.
5. Assert areset for 1 cycle at level=5 -> the next cycle shows level=0, pkt_count=0, m_tvalid=0, s_tready=0; s_tready=1 one cycle after release; no stale data appears on m_*.
6. Randomise s_tvalid and m_tready at 50% for 1000 beats -> a scoreboard shows order and data preserved, level equals pushes minus pops every cycle, and valid is never withdrawn before a handshake.
